instr_fetch_unit: RTL and testbench

- Fetch stage of the CPU pipeline. Sits directly upstream of the IF/ID pipeline register.
- Owns the fetch PC and issues reads to the synchronous instruction memory (1-cycle read latency).
- Buffers returned instructions in a small prefetch FIFO and presents {pc, instr} to IF/ID with a valid/ready handshake.
- Accepts redirects (branch/jump) from later stages; a redirect squashes all younger fetch work.

---
 rtl/instr_fetch_unit.sv | 161 ++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the fetch PC, issues reads to a 1-cycle synchronous instruction memory,
// and buffers the returned {pc, instr} pairs in a small prefetch FIFO ahead of IF/ID.

module ifu_fifo #(
    parameter int W     = 40,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
    logic [PTR_W-1:0]        head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]        count_q, count_d;

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clear) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                mem_d[tail_q] = wdata;
                tail_d        = tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign rdata = mem_q[head_q];
    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));
    assign count = count_q;
endmodule

module instr_fetch_unit #(
    parameter int             PC_W     = 16,
    parameter int             INSTR_W  = 24,
    parameter int             DEPTH    = 2,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr,
    output logic               imem_en,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int SUM_W = CNT_W + 1;

    logic [PC_W-1:0]          fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0]          req_pc_q, req_pc_d;
    logic                     inflight_q, inflight_d;
    logic                     squash_q, squash_d;
    logic                     issue, push, pop;
    logic                     fifo_empty, fifo_full;
    logic [CNT_W-1:0]         fifo_count;
    logic [SUM_W-1:0]         credits;
    logic [PC_W+INSTR_W-1:0]  fifo_rdata;

    assign out_valid = ~fifo_empty;
    assign pop       = out_valid & out_ready;
    assign push      = inflight_q & ~squash_q & ~redirect;

    // Credits count buffered plus in-flight words, so an issued read always finds a free slot.
    assign credits = SUM_W'(fifo_count) + SUM_W'(inflight_q) - SUM_W'(pop);
    assign issue   = rst_n & ~redirect & (credits < SUM_W'(DEPTH));

    assign imem_en   = issue;
    assign imem_addr = fetch_pc_q;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = issue;
        squash_d   = 1'b0;
        if (redirect) begin
            fetch_pc_d = redirect_pc;
            squash_d   = inflight_q;
        end else if (issue) begin
            fetch_pc_d = fetch_pc_q + PC_W'(1);
            req_pc_d   = fetch_pc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
            squash_q   <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
            squash_q   <= squash_d;
        end
    end

    ifu_fifo #(
        .W     (PC_W + INSTR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (redirect),
        .push  (push),
        .wdata ({req_pc_q, imem_rdata}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    assign out_pc    = fifo_rdata[PC_W+INSTR_W-1:INSTR_W];
    assign out_instr = fifo_rdata[INSTR_W-1:0];

    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && fifo_full));
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: hand-computed vector table, directed redirect/wrap/reset
// sequences, and a randomized run against a queue-based model of the fetch stage.

module tb_instr_fetch_unit;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [15:0] out_pc;
    logic [23:0] out_instr;
    logic        imem_en;
    logic [15:0] imem_addr;
    logic [23:0] imem_rdata = '0;

    instr_fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_pc      (out_pc),
        .out_instr   (out_instr),
        .imem_en     (imem_en),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous memory: mem[a] = 0x100000 + a
    always @(posedge clk) if (imem_en) imem_rdata <= 24'h100000 + 24'(imem_addr);

    int n_pass = 0;
    int n_total = 0;

    // Reference model: presented queue, pending-read queue, next fetch address
    int unsigned mq[$];
    int unsigned pq[$];
    logic [15:0] mpc;

    logic        obs_valid, obs_en;
    logic [15:0] obs_pc, obs_addr;

    typedef struct {
        logic        rdy;
        logic        e_valid;
        logic [15:0] e_pc;
        logic        e_en;
        logic [15:0] e_addr;
    } vec_t;
    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        mq.delete();
        pq.delete();
        mpc = 16'h0000;
    endtask

    // One cycle: drive inputs, compare at negedge against the model, advance the model at posedge.
    task automatic step(input logic rd, input logic [15:0] rpc, input logic rdy);
        logic e_valid, e_pop, e_en;
        redirect    = rd;
        redirect_pc = rpc;
        out_ready   = rdy;
        e_valid = (mq.size() > 0);
        e_pop   = e_valid && rdy;
        e_en    = !rd && ((mq.size() + pq.size() - (e_pop ? 1 : 0)) < DEPTH);
        @(negedge clk);
        obs_valid = out_valid;
        obs_pc    = out_pc;
        obs_en    = imem_en;
        obs_addr  = imem_addr;
        chk("out_valid", 32'(out_valid), 32'(e_valid));
        chk("imem_en", 32'(imem_en), 32'(e_en));
        if (e_valid) begin
            chk("out_pc", 32'(out_pc), mq[0]);
            chk("out_instr", 32'(out_instr), 32'h100000 + mq[0]);
        end
        if (e_en) chk("imem_addr", 32'(imem_addr), 32'(mpc));
        @(posedge clk);
        if (rd) begin
            mq.delete();
            pq.delete();
            mpc = rpc;
        end else begin
            if (e_pop) void'(mq.pop_front());
            if (pq.size() > 0) mq.push_back(pq.pop_front());
            if (e_en) begin
                pq.push_back(32'(mpc));
                mpc = mpc + 16'h1;
            end
        end
        #1;
    endtask

    initial begin
        int unsigned h;
        int          got;
        logic [15:0] seen[4];
        logic [15:0] wexp[4];

        tbl[0]  = '{1'b1, 1'b0, 16'h0, 1'b1, 16'h0};
        tbl[1]  = '{1'b1, 1'b0, 16'h0, 1'b1, 16'h1};
        tbl[2]  = '{1'b0, 1'b1, 16'h0, 1'b0, 16'h2};
        tbl[3]  = '{1'b0, 1'b1, 16'h0, 1'b0, 16'h2};
        tbl[4]  = '{1'b0, 1'b1, 16'h0, 1'b0, 16'h2};
        tbl[5]  = '{1'b0, 1'b1, 16'h0, 1'b0, 16'h2};
        tbl[6]  = '{1'b0, 1'b1, 16'h0, 1'b0, 16'h2};
        tbl[7]  = '{1'b1, 1'b1, 16'h0, 1'b1, 16'h2};
        tbl[8]  = '{1'b1, 1'b1, 16'h1, 1'b1, 16'h3};
        tbl[9]  = '{1'b1, 1'b1, 16'h2, 1'b1, 16'h4};
        tbl[10] = '{1'b1, 1'b1, 16'h3, 1'b1, 16'h5};
        wexp[0] = 16'hFFFE; wexp[1] = 16'hFFFF; wexp[2] = 16'h0000; wexp[3] = 16'h0001;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_pc", 32'(out_pc), 32'd0);
        chk("rst_out_instr", 32'(out_instr), 32'd0);
        chk("rst_imem_en", 32'(imem_en), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();

        // Startup latency and backpressure, hand-derived vectors
        for (int i = 0; i < 11; i++) begin
            step(1'b0, 16'h0, tbl[i].rdy);
            chk("tbl_valid", 32'(obs_valid), 32'(tbl[i].e_valid));
            if (tbl[i].e_valid) chk("tbl_pc", 32'(obs_pc), 32'(tbl[i].e_pc));
            chk("tbl_en", 32'(obs_en), 32'(tbl[i].e_en));
            if (tbl[i].e_en) chk("tbl_addr", 32'(obs_addr), 32'(tbl[i].e_addr));
        end

        // Redirect in a busy stream, consumer stalled in the redirect cycle
        repeat (3) step(1'b0, 16'h0, 1'b1);
        step(1'b1, 16'h0040, 1'b0);
        chk("redir_no_en", 32'(obs_en), 32'd0);
        step(1'b0, 16'h0, 1'b1);
        chk("redir_en", 32'(obs_en), 32'd1);
        chk("redir_addr", 32'(obs_addr), 32'h40);
        chk("redir_no_stale1", 32'(obs_valid), 32'd0);
        step(1'b0, 16'h0, 1'b1);
        chk("redir_no_stale2", 32'(obs_valid), 32'd0);
        step(1'b0, 16'h0, 1'b1);
        chk("redir_first_valid", 32'(obs_valid), 32'd1);
        chk("redir_first_pc", 32'(obs_pc), 32'h40);

        // Redirect with a pop in the same cycle
        repeat (2) step(1'b0, 16'h0, 1'b1);
        h = mq[0];
        step(1'b1, 16'h0080, 1'b1);
        chk("popredir_valid", 32'(obs_valid), 32'd1);
        chk("popredir_pc", 32'(obs_pc), h);
        step(1'b0, 16'h0, 1'b1);
        chk("popredir_gap1", 32'(obs_valid), 32'd0);
        step(1'b0, 16'h0, 1'b1);
        chk("popredir_gap2", 32'(obs_valid), 32'd0);
        step(1'b0, 16'h0, 1'b1);
        chk("popredir_next_pc", 32'(obs_pc), 32'h80);

        // PC wrap
        step(1'b1, 16'hFFFE, 1'b1);
        got = 0;
        for (int c = 0; c < 10 && got < 4; c++) begin
            step(1'b0, 16'h0, 1'b1);
            if (obs_valid) begin
                seen[got] = obs_pc;
                got++;
            end
        end
        chk("wrap_count", 32'(got), 32'd4);
        for (int k = 0; k < got; k++) chk("wrap_pc", 32'(seen[k]), 32'(wexp[k]));

        // Async reset mid-stream
        repeat (4) step(1'b0, 16'h0, 1'b1);
        chk("midrst_busy", 32'(out_valid), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_en", 32'(imem_en), 32'd0);
        chk("midrst_pc", 32'(out_pc), 32'd0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(1'b0, 16'h0, 1'b1);
        chk("midrst_first_addr", 32'(obs_addr), 32'h0);
        chk("midrst_first_en", 32'(obs_en), 32'd1);
        step(1'b0, 16'h0, 1'b1);
        step(1'b0, 16'h0, 1'b1);
        chk("midrst_first_valid", 32'(obs_valid), 32'd1);
        chk("midrst_first_pc", 32'(obs_pc), 32'h0);

        // Randomized traffic against the model
        for (int r = 0; r < 600; r++) begin
            logic        rd, rdy;
            logic [15:0] rpc;
            rdy = ($urandom_range(0, 3) != 0);
            rd  = ($urandom_range(0, 15) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFC + $urandom_range(0, 5))
                                               : 16'($urandom_range(0, 65535));
            step(rd, rpc, rdy);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
